// File: rtl/canny_accel_pkg.sv
// Shared constants and arithmetic helpers for the canny_accel grayscale front end.
package canny_accel_pkg;

   // Default luma weights; they sum to 128 so a SHIFT of 7 normalises the result.
   localparam int unsigned COEF_R = 38;
   localparam int unsigned COEF_G = 75;
   localparam int unsigned COEF_B = 15;

   localparam int unsigned SR_W = 64;

   function automatic int unsigned acc_w(input int unsigned prod_w, input int unsigned n_terms);
      return prod_w + $clog2(n_terms);
   endfunction

   function automatic logic [SR_W-1:0] sat_round(input logic [SR_W-1:0] acc,
                                                  input int unsigned     shift,
                                                  input int unsigned     out_w);
      logic [SR_W-1:0] r;
      logic [SR_W-1:0] max_v;
      r     = (acc + (SR_W'(1) << (shift - 1))) >> shift;
      max_v = (SR_W'(1) << out_w) - SR_W'(1);
      return (r > max_v) ? max_v : r;
   endfunction

endpackage

// File: rtl/canny_accel_sync_fifo.sv
// Small synchronous FIFO with full/empty flags and async active-high reset.
module canny_accel_sync_fifo
   import canny_accel_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/canny_accel_gray_acc.sv
// Sums N_TERMS weighted products per pixel, rounds/saturates to a gray sample and
// queues it; the multiplier is stalled via mul_ce whenever the output queue is full.
module canny_accel_gray_acc
   import canny_accel_pkg::*;
#(
   parameter int unsigned PROD_W     = 23,
   parameter int unsigned N_TERMS    = 3,
   parameter int unsigned SHIFT      = 7,
   parameter int unsigned OUT_W      = 8,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              mul_ce,
   input  logic              sync_clr,
   output logic [OUT_W-1:0]  gray_out,
   output logic              gray_valid,
   input  logic              gray_ready,
   output logic [2:0]        term_idx
);

   localparam int unsigned ACC_W = acc_w(PROD_W, N_TERMS);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [2:0]       idx_q, idx_d;
   logic [ACC_W-1:0] acc_sum;
   logic             accept;
   logic             push;
   logic [OUT_W-1:0] push_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic [OUT_W-1:0] fifo_head;

   assign accept  = prod_valid && mul_ce;
   assign acc_sum = acc_q + ACC_W'(prod_in);

   always_comb begin
      acc_d     = acc_q;
      idx_d     = idx_q;
      push      = 1'b0;
      push_data = OUT_W'(sat_round(SR_W'(acc_sum), SHIFT, OUT_W));
      if (sync_clr) begin
         acc_d = '0;
         idx_d = '0;
      end else if (accept) begin
         if (idx_q == 3'(N_TERMS - 1)) begin
            push  = 1'b1;
            acc_d = '0;
            idx_d = '0;
         end else begin
            acc_d = (idx_q == '0) ? ACC_W'(prod_in) : acc_sum;
            idx_d = idx_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         idx_q <= '0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
      end
   end

   canny_accel_sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .push_i  (push),
      .din_i   (push_data),
      .pop_i   (gray_valid && gray_ready),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Full flag derives from the registered count only, so ready never reaches mul_ce combinationally.
   assign mul_ce     = !fifo_full;
   assign gray_valid = !fifo_empty;
   assign gray_out   = fifo_empty ? '0 : fifo_head;
   assign term_idx   = idx_q;

endmodule

// File: tb/tb_canny_accel_gray_acc.sv
// Directed self-checking bench for canny_accel_gray_acc.
module tb_canny_accel_gray_acc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [22:0] prod_in = '0;
   logic        prod_valid = 1'b0;
   logic        mul_ce;
   logic        sync_clr = 1'b0;
   logic [7:0]  gray_out;
   logic        gray_valid;
   logic        gray_ready = 1'b0;
   logic [2:0]  term_idx;

   int tests = 0;
   int fails = 0;

   canny_accel_gray_acc #(
      .PROD_W     (23),
      .N_TERMS    (3),
      .SHIFT      (7),
      .OUT_W      (8),
      .FIFO_DEPTH (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .prod_in    (prod_in),
      .prod_valid (prod_valid),
      .mul_ce     (mul_ce),
      .sync_clr   (sync_clr),
      .gray_out   (gray_out),
      .gray_valid (gray_valid),
      .gray_ready (gray_ready),
      .term_idx   (term_idx)
   );

   always #5 clk = ~clk;

   // Present one product from a negedge, hold it until consumed, return at the next negedge.
   task automatic send(input logic [22:0] v);
      int n;
      n = 0;
      prod_in    = v;
      prod_valid = 1'b1;
      while (!mul_ce && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!mul_ce) begin
         tests++; fails++;
         $display("FAIL send_timeout: mul_ce=%0b required 1", mul_ce);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
      prod_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      @(negedge clk);
      tests++; if (gray_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", gray_valid); end
      tests++; if (gray_out !== 8'd0) begin fails++; $display("FAIL reset_out: got %0d want 0", gray_out); end
      tests++; if (term_idx !== 3'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", term_idx); end
      tests++; if (mul_ce !== 1'b1) begin fails++; $display("FAIL reset_ce: got %0b want 1", mul_ce); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_pixel;
      gray_ready = 1'b1;
      send(23'd9690);
      tests++; if (term_idx !== 3'd1) begin fails++; $display("FAIL basic_idx1: got %0d want 1", term_idx); end
      send(23'd19125);
      tests++; if (term_idx !== 3'd2) begin fails++; $display("FAIL basic_idx2: got %0d want 2", term_idx); end
      send(23'd3825);
      tests++; if (gray_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b want 1", gray_valid); end
      tests++; if (gray_out !== 8'd255) begin fails++; $display("FAIL basic_out: got %0d want 255", gray_out); end
      tests++; if (term_idx !== 3'd0) begin fails++; $display("FAIL basic_idx0: got %0d want 0", term_idx); end
      @(negedge clk);
      tests++; if (gray_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_1cyc: got %0b want 0", gray_valid); end
   endtask

   task automatic test_rounding;
      gray_ready = 1'b1;
      send(23'd0); send(23'd0); send(23'd63);
      tests++; if (gray_valid !== 1'b1 || gray_out !== 8'd0) begin fails++; $display("FAIL round_63: valid=%0b out=%0d want 1/0", gray_valid, gray_out); end
      send(23'd0); send(23'd0); send(23'd64);
      tests++; if (gray_valid !== 1'b1 || gray_out !== 8'd1) begin fails++; $display("FAIL round_64: valid=%0b out=%0d want 1/1", gray_valid, gray_out); end
      @(negedge clk);
   endtask

   task automatic test_saturate;
      gray_ready = 1'b1;
      send(23'd20000); send(23'd20000); send(23'd20000);
      tests++; if (gray_valid !== 1'b1 || gray_out !== 8'd255) begin fails++; $display("FAIL saturate: valid=%0b out=%0d want 1/255", gray_valid, gray_out); end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      gray_ready = 1'b0;
      send(23'd128); send(23'd0); send(23'd0);
      tests++; if (mul_ce !== 1'b1) begin fails++; $display("FAIL bp_ce_one: got %0b want 1", mul_ce); end
      send(23'd256); send(23'd0); send(23'd0);
      tests++; if (mul_ce !== 1'b0) begin fails++; $display("FAIL bp_ce_full: got %0b want 0", mul_ce); end
      prod_in = 23'd384; prod_valid = 1'b1;
      repeat (4) @(negedge clk);
      tests++; if (term_idx !== 3'd0) begin fails++; $display("FAIL bp_held: term_idx=%0d want 0", term_idx); end
      tests++; if (gray_valid !== 1'b1 || gray_out !== 8'd1) begin fails++; $display("FAIL bp_stable: valid=%0b out=%0d want 1/1", gray_valid, gray_out); end
      gray_ready = 1'b1;
      @(negedge clk);
      gray_ready = 1'b0;
      tests++; if (mul_ce !== 1'b1) begin fails++; $display("FAIL bp_ce_back: got %0b want 1", mul_ce); end
      tests++; if (term_idx !== 3'd0) begin fails++; $display("FAIL bp_no_accept_on_pop: term_idx=%0d want 0", term_idx); end
      tests++; if (gray_out !== 8'd2) begin fails++; $display("FAIL bp_out2: got %0d want 2", gray_out); end
      send(23'd384); send(23'd0); send(23'd0);
      tests++; if (mul_ce !== 1'b0) begin fails++; $display("FAIL bp_ce_full2: got %0b want 0", mul_ce); end
      gray_ready = 1'b1;
      @(negedge clk);
      tests++; if (gray_valid !== 1'b1 || gray_out !== 8'd3) begin fails++; $display("FAIL bp_out3: valid=%0b out=%0d want 1/3", gray_valid, gray_out); end
      @(negedge clk);
      tests++; if (gray_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: valid=%0b want 0", gray_valid); end
   endtask

   task automatic test_sync_clr;
      gray_ready = 1'b1;
      send(23'd1000); send(23'd1000);
      sync_clr = 1'b1;
      @(negedge clk);
      sync_clr = 1'b0;
      tests++; if (term_idx !== 3'd0 || gray_valid !== 1'b0) begin fails++; $display("FAIL clr_idle: idx=%0d valid=%0b want 0/0", term_idx, gray_valid); end
      sync_clr = 1'b1; prod_in = 23'd5000; prod_valid = 1'b1;
      @(negedge clk);
      sync_clr = 1'b0; prod_valid = 1'b0;
      tests++; if (term_idx !== 3'd0) begin fails++; $display("FAIL clr_accept: idx=%0d want 0", term_idx); end
      send(23'd128); send(23'd0); send(23'd0);
      tests++; if (gray_valid !== 1'b1 || gray_out !== 8'd1) begin fails++; $display("FAIL clr_pixel: valid=%0b out=%0d want 1/1", gray_valid, gray_out); end
      @(negedge clk);
      tests++; if (gray_valid !== 1'b0) begin fails++; $display("FAIL clr_single: valid=%0b want 0", gray_valid); end
   endtask

   task automatic test_async_reset;
      gray_ready = 1'b0;
      send(23'd128); send(23'd0); send(23'd0);
      send(23'd500);
      tests++; if (gray_valid !== 1'b1 || term_idx !== 3'd1) begin fails++; $display("FAIL ar_setup: valid=%0b idx=%0d want 1/1", gray_valid, term_idx); end
      #2 reset = 1'b1;
      #1;
      tests++; if (gray_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %0b want 0", gray_valid); end
      tests++; if (term_idx !== 3'd0) begin fails++; $display("FAIL ar_idx: got %0d want 0", term_idx); end
      tests++; if (mul_ce !== 1'b1) begin fails++; $display("FAIL ar_ce: got %0b want 1", mul_ce); end
      tests++; if (gray_out !== 8'd0) begin fails++; $display("FAIL ar_out: got %0d want 0", gray_out); end
      #1 reset = 1'b0;
      @(negedge clk);
      gray_ready = 1'b1;
      send(23'd0); send(23'd0); send(23'd256);
      tests++; if (gray_valid !== 1'b1 || gray_out !== 8'd2) begin fails++; $display("FAIL ar_fresh: valid=%0b out=%0d want 1/2", gray_valid, gray_out); end
      @(negedge clk);
      tests++; if (gray_valid !== 1'b0) begin fails++; $display("FAIL ar_drained: valid=%0b want 0", gray_valid); end
   endtask

   initial begin
      test_reset();
      test_basic_pixel();
      test_rounding();
      test_saturate();
      test_backpressure();
      test_sync_clr();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/canny_accel_gray_acc.md
Name: canny_accel_gray_acc

Overview:
- Downstream consumer of the 4-stage 16x7 unsigned multiplier in the canny_accel grayscale front end.
- Accumulates N_TERMS consecutive products (R, G, B weighted terms) into one sum per pixel, then rounds, shifts and saturates it to an 8-bit gray sample.
- Buffers results in a small output FIFO with valid/ready handshake.
- Drives the multiplier's ce so the whole multiplier pipeline freezes under downstream backpressure.

Parameters:
PROD_W, 23, width of incoming product (multiplier dout)
N_TERMS, 3, products summed per output pixel (2..7)
SHIFT, 7, right shift applied after rounding (1..15)
OUT_W, 8, output sample width
FIFO_DEPTH, 2, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
prod_in  in  PROD_W  product from multiplier dout
prod_valid  in  1  prod_in carries a real product this cycle (tracked alongside the multiplier pipe)
mul_ce  out  1  clock enable to multiplier; high = pipe advances and prod_in is consumed
sync_clr  in  1  synchronous abandon of any partially accumulated pixel
gray_out  out  OUT_W  gray sample, FIFO head
gray_valid  out  1  FIFO non-empty
gray_ready  in  1  downstream accepts gray_out when gray_valid
term_idx  out  3  current term index 0..N_TERMS-1 (debug/status)

Behaviour:
- Reset values: mul_ce=1 (FIFO empty), gray_valid=0, gray_out=0, term_idx=0, accumulator=0, FIFO pointers=0.
- Accumulator width ACC_W = PROD_W + clog2(N_TERMS); the sum never overflows.
- Accept: a product is consumed when prod_valid && mul_ce at the clock edge. prod_valid with mul_ce=0 is ignored; the multiplier holds the value.
- mul_ce = !fifo_full, registered view only. No same-cycle pass-through from gray_ready.
- term_idx state machine (ACCUM), per accept:
  - term_idx < N_TERMS-1: acc <= acc + prod_in (acc <= prod_in when term_idx==0); term_idx++.
  - term_idx == N_TERMS-1: compute final = acc + prod_in; push result; acc <= 0; term_idx <= 0.
- Result arithmetic: r = (final + 2^(SHIFT-1)) >> SHIFT, unsigned. If r > 2^OUT_W-1, output 2^OUT_W-1 (saturate), else r[OUT_W-1:0].
- Latency: the final term accepted at edge k makes gray_valid=1 after edge k, i.e. visible the cycle after acceptance.
- FIFO:
  - Pop on gray_valid && gray_ready.
  - Simultaneous push and pop when full is impossible, because mul_ce=0 when full.
  - Simultaneous push and pop when non-full: occupancy unchanged, order preserved.
  - gray_out holds stable while gray_valid && !gray_ready.
- sync_clr: acc <= 0, term_idx <= 0. If it coincides with an accept, the accepted product is discarded. FIFO contents are untouched.
- Reset mid-pixel or mid-stall: everything returns to reset values immediately. The partial pixel and FIFO contents are lost.
- prod_valid=0 cycles between terms are allowed; accumulation state is held.

Decomposition:
- Shared package canny_accel_pkg:
  - ACC_W computation function.
  - Rounding/saturate function sat_round(acc, SHIFT, OUT_W).
  - Default coefficient constants (38, 75, 15; sum 128 = 2^SHIFT) used by the upstream coefficient mux.
- One sub-module: canny_accel_sync_fifo (parameterised width/depth, full/empty flags, async active-high reset).

Test Plan:
- Basic pixel: products 9690, 19125, 3825 (255 x 38/75/15) with gray_ready=1 -> one gray_out=255, gray_valid for 1 cycle, term_idx returns to 0.
- Rounding edges: sums 63 and 64 (terms 0, 0, 63 / 0, 0, 64) -> gray_out 0 then 1.
- Saturation: three products of 20000 (sum 60000) -> gray_out=255.
- Backpressure:
  - Stimulus: gray_ready=0, stream 3 pixels with sums 128, 256, 384.
  - After 2 pixels mul_ce drops to 0 and the third pixel's products are held, not consumed.
  - After gray_ready=1: outputs 1, 2, 3 in order, with mul_ce reasserting when the FIFO leaves full.
- sync_clr after 2 terms (1000, 1000), then full pixel 128, 0, 0 -> single output 1; no output from the partial pixel.
- Async reset asserted mid-pixel with FIFO holding one entry -> gray_valid=0, term_idx=0, mul_ce=1 immediately, without waiting for a clock; the next 3 products form a fresh pixel.
